// File: rtl/sd122_arb_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
package sd122_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotate-priority picker: first set bit of req searching from ptr upward, mod 4.
module rr_pick4
    import sd122_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        any    = |req;
        idx    = '0;
        onehot = '0;
        cand   = '0;
        // Walk from the lowest priority back to ptr so the closest requester wins last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_mux_arbiter_4x1.sv
// Round-robin arbiter sharing one N-bit 4:1 mux among four requesters, with a hold limit
// that forces a hand-over when another requester is waiting.
module rr_mux_arbiter_4x1
    import sd122_arb_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [N-1:0]       in0,
    input  logic [N-1:0]       in1,
    input  logic [N-1:0]       in2,
    input  logic [N-1:0]       in3,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic [N-1:0]       out_data,
    output logic               out_valid
);

    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [7:0]         hold_q, hold_d;
    logic [N-1:0]       data_q, data_d;
    logic               valid_q, valid_d;

    logic [NUM_REQ-1:0] others;
    logic [NUM_REQ-1:0] pick_req;
    logic               pick_any;
    logic [SEL_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               cur_req;
    logic               at_limit;
    logic               release_now;
    logic               timeout_now;
    logic [N-1:0]       mux_data;

    always_comb begin
        others         = req;
        others[sel_q]  = 1'b0;
        cur_req        = req[sel_q];
        at_limit       = (hold_q == HoldLast);
        release_now    = ~cur_req;
        timeout_now    = at_limit && (|others);
        // While granted, the holder is masked so a timed-out requester cannot win itself back.
        pick_req       = (state_q == ST_GRANT) ? others : req;
    end

    rr_pick4 u_pick (
        .req    (pick_req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        hold_d  = hold_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    gnt_d   = pick_onehot;
                    sel_d   = pick_idx;
                    hold_d  = '0;
                    ptr_d   = pick_idx + 1'b1;
                end
            end
            ST_GRANT: begin
                if (release_now || timeout_now) begin
                    if (pick_any) begin
                        gnt_d  = pick_onehot;
                        sel_d  = pick_idx;
                        hold_d = '0;
                        ptr_d  = pick_idx + 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        sel_d   = '0;
                        hold_d  = '0;
                    end
                end else if (!at_limit) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        unique case (sel_q)
            2'd0:    mux_data = in0;
            2'd1:    mux_data = in1;
            2'd2:    mux_data = in2;
            default: mux_data = in3;
        endcase
        valid_d = (state_q == ST_GRANT) && cur_req;
        data_d  = valid_d ? mux_data : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            hold_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: doc/rr_mux_arbiter_4x1.md
Name: rr_mux_arbiter_4x1

Overview:
- Round-robin arbiter and sequencer that shares one N-bit, 4-input datapath mux among four requesters.
- Grants one requester at a time and holds the grant until it is released or a hold limit expires.
- Drives the mux select and registers the selected data onto a single output with a valid flag.
- Sits between the four producer channels and the shared downstream consumer.

Parameters:
- N, 4: data width of each input and of the output.
- MAX_HOLD, 8: maximum consecutive cycles one requester may hold the grant while another requester is waiting. Legal range 2..255.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request vector; bit i = requester i wants the datapath.
- in0, in1, in2, in3  input  N each  requester data, selected by the current grant.
- gnt  output  4  one-hot grant, registered; all zeros when idle.
- sel  output  2  registered mux select = index of the granted requester; 0 when idle.
- out_data  output  N  registered selected data.
- out_valid  output  1  registered; high when out_data holds data from a granted, still-requesting source.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While rst_n=0, force state=IDLE, gnt=0, sel=0, out_data=0, out_valid=0, ptr=0, hold_cnt=0.
- ptr (2 bits) is the highest-priority index for the next arbitration. Search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4.
- State IDLE:
  - If req != 0 at the edge, grant the first requesting index in search order.
  - Set gnt to one-hot, sel to that index, hold_cnt=0, state=GRANT.
  - On every grant, set ptr = winner+1 (mod 4).
- State GRANT, evaluated each edge:
  - Release: req[sel]=0.
  - Timeout: hold_cnt==MAX_HOLD-1 and (req with bit sel masked) != 0.
  - On release or timeout, if any other request is pending, re-arbitrate at the same edge. This gives a back-to-back grant with no idle cycle; the releasing or timed-out index has lowest priority because ptr = its index+1.
  - If release and no other request is pending, go to IDLE with gnt=0 and sel=0.
  - If timeout fires, a competitor exists by definition, so a re-grant always follows.
  - Otherwise stay in GRANT and increment hold_cnt. hold_cnt saturates at MAX_HOLD-1 when no competitor is waiting.
- Data path:
  - out_data <= mux(sel) when (state==GRANT && req[sel]); otherwise out_data holds its value.
  - out_valid <= (state==GRANT && req[sel]).
  - Latency: a request accepted at edge k gets gnt at k. The first valid data, from the input values present between k and k+1, appears at edge k+1.
- Boundary cases:
  - Simultaneous requests are resolved strictly by ptr.
  - A requester that drops and re-raises req while still granted loses the grant at the drop edge.
  - Request changes on non-granted lines never disturb the current grant.
  - gnt is always one-hot or zero; sel always equals the one-hot index.
  - Asserting reset mid-grant clears all state immediately.
  - After rst_n deasserts, the first arbitration starts with ptr=0.

Decomposition:
- Shared package (sd122_arb_pkg):
  - state typedef/localparams ST_IDLE=1'b0, ST_GRANT=1'b1.
  - NUM_REQ=4 and SEL_W=2 constants.
- Sub-module rr_pick4: combinational rotate-priority picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: any, idx[1:0], onehot[3:0].
- The N-bit 4:1 data selection is a case on sel inside the top module.

Test Plan:
- Reset and idle:
  - Stimulus: hold rst_n=0, then release with req=0.
  - Required: gnt=0, sel=0, out_valid=0, out_data=0 for 5 cycles.
- Single requester, N=4:
  - Stimulus: req=0001, in0=4'hA for 3 cycles, then req=0.
  - Required: gnt=0001 on the first edge; out_valid=1 with out_data=A for 3 cycles; then gnt=0 and out_valid=0.
- Round-robin fairness:
  - Stimulus: req=1111 held, each granted requester drops its req after 2 granted cycles and re-raises it the next cycle.
  - Required: grant order 0,1,2,3,0; no idle cycle between grants.
- Timeout, MAX_HOLD=8:
  - Stimulus: req=0011 held constantly.
  - Required: requester 0 holds gnt exactly 8 cycles, then gnt=0010 for 8 cycles, then back to 0001.
- Mid-grant reset:
  - Stimulus: assert rst_n=0 during GRANT with sel=2.
  - Required: gnt, sel, out_valid and out_data clear asynchronously. After release with req=0100, ptr restarts at 0 and requester 2 is granted.
- Non-granted churn:
  - Stimulus: requester 1 granted while req[3] and req[2] toggle every cycle.
  - Required: gnt stays 0010 until req[1] drops or MAX_HOLD expires.
